idma_req_queue: RTL and testbench

Elastic buffer between the 64-bit register frontend and the iDMA backend. Accepts burst requests from the frontend over ready/valid, stores up to `Depth` of them in order, and issues them to the backend. It also counts transfers issued but not yet completed, stalls issue once `MaxInflight` are outstanding, and reports queue and in-flight status for the frontend's status register.

---
 rtl/idma_req_queue_pkg.sv | 23 ++
 rtl/idma_inflight_counter.sv | 47 ++++
 rtl/idma_req_queue.sv | 106 ++++++++++
 tb/tb_idma_req_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_req_queue_pkg.sv
// Shared width helpers for idma_req_queue: status counter and pointer widths
// derived from the Depth / MaxInflight parameters.
package idma_req_queue_pkg;

   localparam int unsigned MaxDepth       = 64;
   localparam int unsigned MaxInflightCap = 255;

   // Width of usage_t: must hold 0..depth inclusive.
   function automatic int unsigned usage_width(input int unsigned depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   // Width of inflight_t: must hold 0..max_inflight inclusive.
   function automatic int unsigned inflight_width(input int unsigned max_inflight);
      return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
   endfunction

   // At least one bit, so a single-entry queue still has a legal pointer.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/idma_inflight_counter.sv
// Outstanding-transfer counter: +1 on issue, -1 on retire, with a sticky flag
// for completions that arrive while nothing is outstanding.
module idma_inflight_counter
   import idma_req_queue_pkg::*;
#(
   parameter int unsigned MaxInflight = 8,
   localparam int unsigned CntW = inflight_width(MaxInflight)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            issue_i,
   input  logic            retire_i,
   output logic            cap_o,
   output logic [CntW-1:0] count_o,
   output logic            err_o
);

   logic [CntW-1:0] count_q, count_d;
   logic            err_q, err_d;

   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      if (issue_i && !retire_i) begin
         count_d = count_q + CntW'(1);
      end else if (retire_i && !issue_i) begin
         // A retire with nothing outstanding is flagged, never underflowed.
         if (count_q == '0) err_d = 1'b1;
         else               count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign cap_o   = (count_q >= CntW'(MaxInflight));
   assign count_o = count_q;
   assign err_o   = err_q;

endmodule

// File: rtl/idma_req_queue.sv
// In-order elastic request buffer between register frontend and iDMA backend,
// with in-flight issue cap. Optional IDMA_REQ_QUEUE_FALL_THROUGH_EN bypasses an empty queue.
module idma_req_queue
   import idma_req_queue_pkg::*;
#(
   parameter type         burst_req_t = logic,
   parameter int unsigned Depth       = 4,
   parameter int unsigned MaxInflight = 8,
   localparam int unsigned UsageW = usage_width(Depth),
   localparam int unsigned InflW  = inflight_width(MaxInflight)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  burst_req_t        req_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   output burst_req_t        req_o,
   output logic              req_valid_o,
   input  logic              req_ready_i,
   input  logic              trans_complete_i,
   output logic [UsageW-1:0] usage_o,
   output logic [InflW-1:0]  inflight_o,
   output logic              idle_o,
   output logic              cpl_err_o
);

   localparam int unsigned PtrW = ptr_width(Depth);

   burst_req_t        mem_q [Depth];
   burst_req_t        mem_d [Depth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [UsageW-1:0] usage_q, usage_d;
   logic              full, empty, cap, push, pop, wr_en, rd_en;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full  = (usage_q == UsageW'(Depth));
   assign empty = (usage_q == '0);

   // Ready depends only on registered occupancy, so a pop never frees a
   // slot for a same-cycle push when full.
   assign req_ready_o = !full && !rst_i;
   assign push        = req_valid_i && req_ready_o;
   assign pop         = req_valid_o && req_ready_i;

`ifdef IDMA_REQ_QUEUE_FALL_THROUGH_EN
   assign req_o       = empty ? req_i : mem_q[rd_ptr_q];
   assign req_valid_o = !rst_i && !cap && (!empty || req_valid_i);
   assign wr_en       = push && !(empty && pop);
   assign rd_en       = pop && !empty;
`else
   assign req_o       = mem_q[rd_ptr_q];
   assign req_valid_o = !rst_i && !cap && !empty;
   assign wr_en       = push;
   assign rd_en       = pop;
`endif

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      usage_d  = usage_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = req_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_en && !rd_en)      usage_d = usage_q + UsageW'(1);
      else if (rd_en && !wr_en) usage_d = usage_q - UsageW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usage_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usage_q  <= usage_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   idma_inflight_counter #(
      .MaxInflight (MaxInflight)
   ) i_inflight (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .issue_i  (pop),
      .retire_i (trans_complete_i),
      .cap_o    (cap),
      .count_o  (inflight_o),
      .err_o    (cpl_err_o)
   );

   assign usage_o = usage_q;
   assign idle_o  = empty && (inflight_o == '0);

endmodule

// File: tb/tb_idma_req_queue.sv
// Self-checking bench for idma_req_queue (Depth 4, MaxInflight 2) with an
// in-order scoreboard on the backend side.
module tb_idma_req_queue;

   typedef logic [31:0] req_t;

   logic       clk_i = 1'b0;
   logic       rst_i;
   req_t       req_i, req_o;
   logic       req_valid_i, req_ready_o, req_valid_o, req_ready_i, trans_complete_i;
   logic [2:0] usage_o;
   logic [1:0] inflight_o;
   logic       idle_o, cpl_err_o;

   int   checks = 0;
   int   errors = 0;
   int   issued = 0;
   req_t sb [$];

   always #5 clk_i = ~clk_i;

   idma_req_queue #(
      .burst_req_t (req_t),
      .Depth       (4),
      .MaxInflight (2)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .req_i            (req_i),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_o            (req_o),
      .req_valid_o      (req_valid_o),
      .req_ready_i      (req_ready_i),
      .trans_complete_i (trans_complete_i),
      .usage_o          (usage_o),
      .inflight_o       (inflight_o),
      .idle_o           (idle_o),
      .cpl_err_o        (cpl_err_o)
   );

   // Records handshakes of the current cycle into the scoreboard, then
   // advances to 2 time units after the next rising edge.
   task automatic tick();
      req_t e;
      #1;
      if (req_valid_i && req_ready_o) sb.push_back(req_i);
      if (req_valid_o && req_ready_i) begin
         issued++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL order: issued %0h with no request expected", req_o);
         end else begin
            e = sb.pop_front();
            if (req_o !== e) begin
               errors++;
               $display("FAIL order: issued %0h expected %0h", req_o, e);
            end
         end
      end
      @(posedge clk_i);
      #2;
   endtask

   // Retire outstanding transfers and issue everything queued, bounded.
   task automatic drain();
      bit done = 0;
      req_valid_i = 1'b0;
      req_ready_i = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (sb.size() == 0 && inflight_o == 2'd0 && usage_o == 3'd0) done = 1;
         else begin
            trans_complete_i = (inflight_o != 2'd0);
            tick();
         end
      end
      trans_complete_i = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: usage %0d inflight %0d pending %0d expected all 0",
                  usage_o, inflight_o, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      req_valid_i = 1'b1;
      req_i = 32'hdead;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #3;
         checks++;
         if (req_ready_o !== 1'b0 || req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: ready %b valid %b expected 0 0", req_ready_o, req_valid_o);
         end
      end
      rst_i = 1'b0;
      req_valid_i = 1'b0;
      #1;
      checks++; if (usage_o !== 3'd0)    begin errors++; $display("FAIL reset_usage: got %0d expected 0", usage_o); end
      checks++; if (inflight_o !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight_o); end
      checks++; if (idle_o !== 1'b1)     begin errors++; $display("FAIL reset_idle: got %b expected 1", idle_o); end
      checks++; if (cpl_err_o !== 1'b0)  begin errors++; $display("FAIL reset_cpl_err: got %b expected 0", cpl_err_o); end
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
      tick();
   endtask

   task automatic test_fill();
      int start = issued;
      req_ready_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         req_i = req_t'(i);
         req_valid_i = 1'b1;
         #1;
         checks++;
         if (req_ready_o !== (i <= 4)) begin
            errors++;
            $display("FAIL fill_ready: push %0d ready %b expected %b", i, req_ready_o, (i <= 4));
         end
         if (i < 5) tick();
      end
      checks++; if (usage_o !== 3'd4) begin errors++; $display("FAIL fill_usage: got %0d expected 4", usage_o); end
      req_ready_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 1'b0 || req_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL full_pop_no_push: ready %b valid %b expected 0 1", req_ready_o, req_valid_o);
      end
      tick();
      trans_complete_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 1'b1 || usage_o !== 3'd3) begin
         errors++;
         $display("FAIL freed_slot: ready %b usage %0d expected 1 3", req_ready_o, usage_o);
      end
      tick();
      trans_complete_i = 1'b0;
      drain();
      checks++;
      if (issued - start != 5) begin
         errors++;
         $display("FAIL fill_count: issued %0d expected 5", issued - start);
      end
   endtask

   task automatic test_cap();
      req_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_i = 32'h100 + req_t'(i);
         req_valid_i = 1'b1;
         tick();
      end
      req_valid_i = 1'b0;
      req_ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (req_valid_o !== 1'b1) begin errors++; $display("FAIL cap_issue%0d: valid %b expected 1", i, req_valid_o); end
         tick();
      end
      #1;
      checks++;
      if (req_valid_o !== 1'b0 || inflight_o !== 2'd2) begin
         errors++;
         $display("FAIL cap_stall: valid %b inflight %0d expected 0 2", req_valid_o, inflight_o);
      end
      checks++;
      if (req_o !== 32'h102) begin errors++; $display("FAIL cap_head: req_o %0h expected 102", req_o); end
      tick();
      trans_complete_i = 1'b1;
      #1;
      checks++;
      if (req_valid_o !== 1'b0) begin errors++; $display("FAIL cap_hold: valid %b expected 0", req_valid_o); end
      tick();
      // Third request issues while another completion lands: count holds.
      #1;
      checks++;
      if (inflight_o !== 2'd1 || req_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL cap_release: inflight %0d valid %b expected 1 1", inflight_o, req_valid_o);
      end
      tick();
      #1;
      checks++;
      if (inflight_o !== 2'd1) begin errors++; $display("FAIL issue_and_cpl: inflight %0d expected 1", inflight_o); end
      tick();
      trans_complete_i = 1'b0;
      #1;
      checks++;
      if (inflight_o !== 2'd0) begin errors++; $display("FAIL cap_retire: inflight %0d expected 0", inflight_o); end
      tick();
   endtask

   task automatic test_push_pop();
      req_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_i = 32'h200 + req_t'(i);
         req_valid_i = 1'b1;
         tick();
      end
      req_i = 32'h202;
      req_ready_i = 1'b1;
      #1;
      checks++;
      if (usage_o !== 3'd2 || req_valid_o !== 1'b1 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL pushpop_setup: usage %0d valid %b ready %b expected 2 1 1", usage_o, req_valid_o, req_ready_o);
      end
      tick();
      req_valid_i = 1'b0;
      req_ready_i = 1'b0;
      #1;
      checks++;
      if (usage_o !== 3'd2) begin errors++; $display("FAIL pushpop_usage: got %0d expected 2", usage_o); end
      tick();
      drain();
   endtask

   task automatic test_back_to_back();
      int start = issued;
      for (int i = 0; i < 8; i++) begin
         req_i = $urandom;
         req_valid_i = 1'b1;
         req_ready_i = 1'b1;
         trans_complete_i = (inflight_o != 2'd0);
         #1;
         checks++;
         if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: beat %0d got %b expected 1", i, req_ready_o); end
         tick();
      end
      trans_complete_i = 1'b0;
      drain();
      checks++;
      if (issued - start != 8) begin errors++; $display("FAIL b2b_count: issued %0d expected 8", issued - start); end
   endtask

   task automatic test_latency();
      req_ready_i = 1'b1;
      req_i = 32'h300;
      req_valid_i = 1'b1;
      #1;
`ifdef IDMA_REQ_QUEUE_FALL_THROUGH_EN
      checks++;
      if (req_valid_o !== 1'b1 || req_o !== 32'h300) begin
         errors++;
         $display("FAIL ft_same_cycle: valid %b req %0h expected 1 300", req_valid_o, req_o);
      end
      tick();
      req_valid_i = 1'b0;
      #1;
      checks++;
      if (usage_o !== 3'd0) begin errors++; $display("FAIL ft_usage: got %0d expected 0", usage_o); end
`else
      checks++;
      if (req_valid_o !== 1'b0) begin errors++; $display("FAIL lat_same_cycle: valid %b expected 0", req_valid_o); end
      tick();
      req_valid_i = 1'b0;
      #1;
      checks++;
      if (req_valid_o !== 1'b1 || usage_o !== 3'd1) begin
         errors++;
         $display("FAIL lat_next_cycle: valid %b usage %0d expected 1 1", req_valid_o, usage_o);
      end
`endif
      tick();
      drain();
   endtask

   task automatic test_spurious();
      req_valid_i = 1'b0;
      trans_complete_i = 1'b1;
      #1;
      checks++;
      if (cpl_err_o !== 1'b0 || inflight_o !== 2'd0) begin
         errors++;
         $display("FAIL spur_pre: err %b inflight %0d expected 0 0", cpl_err_o, inflight_o);
      end
      tick();
      trans_complete_i = 1'b0;
      #1;
      checks++;
      if (cpl_err_o !== 1'b1 || inflight_o !== 2'd0) begin
         errors++;
         $display("FAIL spur_set: err %b inflight %0d expected 1 0", cpl_err_o, inflight_o);
      end
      req_ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_i = 32'h400 + req_t'(i);
         req_valid_i = 1'b1;
         tick();
      end
      drain();
      #1;
      checks++;
      if (cpl_err_o !== 1'b1 || inflight_o !== 2'd0) begin
         errors++;
         $display("FAIL spur_sticky: err %b inflight %0d expected 1 0", cpl_err_o, inflight_o);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      req_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_i = 32'h500 + req_t'(i);
         req_valid_i = 1'b1;
         tick();
      end
      req_valid_i = 1'b0;
      req_ready_i = 1'b1;
      tick();
      rst_i = 1'b1;
      #1;
      checks++;
      if (req_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_force: valid %b ready %b expected 0 0", req_valid_o, req_ready_o);
      end
      tick();
      rst_i = 1'b0;
      req_ready_i = 1'b0;
      sb.delete();
      #1;
      checks++;
      if (usage_o !== 3'd0 || inflight_o !== 2'd0 || cpl_err_o !== 1'b0 || idle_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_clear: usage %0d inflight %0d err %b idle %b expected 0 0 0 1",
                  usage_o, inflight_o, cpl_err_o, idle_o);
      end
      tick();
   endtask

   initial begin
      rst_i = 1'b1;
      req_i = '0;
      req_valid_i = 1'b0;
      req_ready_i = 1'b0;
      trans_complete_i = 1'b0;
      test_reset();
      test_fill();
      test_cap();
      test_push_pop();
      test_back_to_back();
      test_latency();
      test_spurious();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
